// File: rtl/imem_loader_if.sv
// Stream-in handshake and byte-write bus of the boot program loader.
// The loader takes the master side; the byte source and memory take the slave side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum frame, writes payload bytes to
// instruction memory one cycle after acceptance, and holds the core until the checksum matches.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 400,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;

    // Largest payload that fits between BASE_ADDR and the end of memory.
    localparam logic [31:0] LIMIT = 32'(MEM_BYTES) - BASE_ADDR;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        inReady;
    logic        accept;
    logic [31:0] fullLen;

    assign inReady = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign accept  = bus.in_valid && inReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEN;
            len_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The range check uses the complete 32-bit length, including the byte arriving now.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        count_d = count_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fullLen = {bus.in_data, len_q[23:0]};

        unique case (state_q)
            LEN: begin
                if (accept) begin
                    len_d[{idx_q, 3'b000} +: 8] = bus.in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (fullLen > LIMIT) begin
                            state_d = ERR;
                        end else if (fullLen == 32'd0) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + count_q;
                    wdata_d = bus.in_data;
                    sum_d   = sum_q + bus.in_data;
                    count_d = count_q + 32'd1;
                    if (count_d == len_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    assign bus.in_ready  = inReady;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);

endmodule
